// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture controller and other consumers of
// deserialized ADC frames.
package adc_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int OVF_W = 8;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int ch_idx_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

    // Bit offset of channel ch inside a packed frame.
    function automatic int ch_lsb(input int ch, input int data_width);
        return ch * data_width;
    endfunction

endpackage

// File: rtl/adc_ch_scheduler.sv
// One-frame holding buffer plus channel-mask walker driving the readout stream.
// A frame is held as a pending-channel mask; the buffer is full while any bit remains.
module adc_ch_scheduler
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CH_NUM     = 8,
    parameter int CH_W       = ch_idx_w(CH_NUM)
) (
    input  logic                         CLKR,
    input  logic                         RST,
    input  logic                         clear,
    input  logic [CH_NUM-1:0]            mask,
    input  logic                         load,
    input  logic [CH_NUM*DATA_WIDTH-1:0] frame_in,
    input  logic                         clast_in,
    input  logic                         mark_last,
    output logic                         busy,
    output logic                         last_hs,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_ch,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_flast,
    output logic                         out_clast
);

    logic [CH_NUM*DATA_WIDTH-1:0] frame_q;
    logic [CH_NUM-1:0]            pend_q;
    logic [CH_NUM-1:0]            pend_rest;
    logic                         clast_q;
    logic [CH_W-1:0]              cur_ch;
    logic [DATA_WIDTH-1:0]        lane [CH_NUM];
    logic                         hs;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        assign lane[i] = frame_q[ch_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end

    // Lowest pending channel is the current beat.
    always_comb begin
        cur_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (pend_q[i]) cur_ch = CH_W'(i);
        end
    end

    always_comb begin
        pend_rest         = pend_q;
        pend_rest[cur_ch] = 1'b0;
    end

    assign busy      = |pend_q;
    assign out_valid = busy & ~clear;
    assign hs        = out_valid & out_ready;
    assign out_flast = out_valid & ~(|pend_rest);
    assign last_hs   = hs & out_flast;
    // A link loss in the same cycle as the final beat must still tag that beat.
    assign out_clast = out_flast & (clast_q | mark_last);
    assign out_ch    = cur_ch;
    assign out_data  = lane[cur_ch];

    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            pend_q  <= '0;
            frame_q <= '0;
            clast_q <= 1'b0;
        end else if (clear) begin
            pend_q  <= '0;
            clast_q <= 1'b0;
        end else if (load) begin
            pend_q  <= mask;
            frame_q <= frame_in;
            clast_q <= clast_in;
        end else begin
            if (hs) pend_q <= pend_rest;
            if (mark_last) clast_q <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arm/trigger FSM, frame counting and drop accounting
// in front of the channel scheduler that feeds the readout FIFO.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CH_NUM     = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         CLKR,
    input  logic                         RST,
    input  logic                         ARM,
    input  logic                         ABORT,
    input  logic                         SW_TRIG,
    input  logic                         EXT_TRIG,
    input  logic [CNT_WIDTH-1:0]         NSAMPLES,
    input  logic [CH_NUM-1:0]            CH_MASK,
    input  logic                         FRAME_OK,
    input  logic                         ENB,
    input  logic [CH_NUM*DATA_WIDTH-1:0] DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [ch_idx_w(CH_NUM)-1:0]  OUT_CH,
    output logic [DATA_WIDTH-1:0]        OUT_DATA,
    output logic                         OUT_FLAST,
    output logic                         OUT_CLAST,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         LINK_ERR,
    output logic [OVF_W-1:0]             OVF_CNT
);

    state_t               state_q, state_d;
    logic                 ext_s1, ext_s2, ext_s3;
    logic                 trig;
    logic [CNT_WIDTH-1:0] rem_q;
    logic [CH_NUM-1:0]    mask_q;
    logic                 link_err_q;
    logic [OVF_W-1:0]     ovf_q;
    logic                 last_frame;
    logic                 buf_busy, buf_last_hs;
    logic                 arm_ok, link_loss, frame_take, load, drop, mark_last;

    // EXT_TRIG is asynchronous: two flops to synchronize, a third for the edge.
    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_s3 <= 1'b0;
        end else begin
            ext_s1 <= EXT_TRIG;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
        end
    end

    assign trig       = SW_TRIG | (ext_s2 & ~ext_s3);
    assign last_frame = (rem_q == CNT_WIDTH'(1));

    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (arm_ok) state_d = ST_ARMED;
                ST_ARMED:   if (trig && FRAME_OK) state_d = ST_CAPTURE;
                ST_CAPTURE: if (link_loss || (frame_take && last_frame)) state_d = ST_DRAIN;
                ST_DRAIN:   if (!buf_busy) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // ABORT masks every other action in its cycle.
    always_comb begin
        arm_ok     = 1'b0;
        link_loss  = 1'b0;
        frame_take = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        mark_last  = 1'b0;
        DONE       = 1'b0;
        BUSY       = (state_q != ST_IDLE);
        if (!ABORT) begin
            case (state_q)
                ST_IDLE: arm_ok = ARM && (NSAMPLES != '0);
                ST_CAPTURE: begin
                    if (!FRAME_OK) begin
                        link_loss = 1'b1;
                        mark_last = 1'b1;
                    end else if (ENB) begin
                        frame_take = 1'b1;
                        if (mask_q != '0) begin
                            if (!buf_busy || buf_last_hs) load = 1'b1;
                            else                          drop = 1'b1;
                        end
                    end
                end
                ST_DRAIN: DONE = !buf_busy;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLKR or posedge RST) begin
        if (RST) begin
            rem_q      <= '0;
            mask_q     <= '0;
            link_err_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            if (arm_ok) begin
                rem_q      <= NSAMPLES;
                mask_q     <= CH_MASK;
                link_err_q <= 1'b0;
                ovf_q      <= '0;
            end
            if (frame_take) rem_q <= rem_q - CNT_WIDTH'(1);
            if (link_loss) link_err_q <= 1'b1;
            if (drop && (ovf_q != {OVF_W{1'b1}})) ovf_q <= ovf_q + OVF_W'(1);
        end
    end

    assign LINK_ERR = link_err_q;
    assign OVF_CNT  = ovf_q;

    adc_ch_scheduler #(
        .DATA_WIDTH(DATA_WIDTH),
        .CH_NUM    (CH_NUM)
    ) u_sched (
        .CLKR     (CLKR),
        .RST      (RST),
        .clear    (ABORT),
        .mask     (mask_q),
        .load     (load),
        .frame_in (DATA),
        .clast_in (last_frame),
        .mark_last(mark_last),
        .busy     (buf_busy),
        .last_hs  (buf_last_hs),
        .out_valid(OUT_VALID),
        .out_ready(OUT_READY),
        .out_ch   (OUT_CH),
        .out_data (OUT_DATA),
        .out_flast(OUT_FLAST),
        .out_clast(OUT_CLAST)
    );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: scenario tasks against a queue-based model of
// the capture rules, with randomized frame data, timing and backpressure.
module tb_adc_capture_ctrl;

    localparam int DW  = 12;
    localparam int CHN = 8;
    localparam int CW  = 16;
    localparam int M_IDLE = 0, M_ARMD = 1, M_CAP = 2, M_DRN = 3;

    logic          CLKR = 1'b0;
    logic          RST = 1'b1, ARM = 1'b0, ABORT = 1'b0, SW_TRIG = 1'b0, EXT_TRIG = 1'b0;
    logic [CW-1:0] NSAMPLES = '0;
    logic [CHN-1:0] CH_MASK = '0;
    logic          FRAME_OK = 1'b1, ENB = 1'b0, OUT_READY = 1'b1;
    logic [CHN*DW-1:0] DATA = '0;
    logic          OUT_VALID, OUT_FLAST, OUT_CLAST, BUSY, DONE, LINK_ERR;
    logic [2:0]    OUT_CH;
    logic [DW-1:0] OUT_DATA;
    logic [7:0]    OVF_CNT;

    adc_capture_ctrl #(.DATA_WIDTH(DW), .CH_NUM(CHN), .CNT_WIDTH(CW)) dut (
        .CLKR(CLKR), .RST(RST), .ARM(ARM), .ABORT(ABORT), .SW_TRIG(SW_TRIG),
        .EXT_TRIG(EXT_TRIG), .NSAMPLES(NSAMPLES), .CH_MASK(CH_MASK),
        .FRAME_OK(FRAME_OK), .ENB(ENB), .DATA(DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_CH(OUT_CH), .OUT_DATA(OUT_DATA),
        .OUT_FLAST(OUT_FLAST), .OUT_CLAST(OUT_CLAST), .BUSY(BUSY), .DONE(DONE),
        .LINK_ERR(LINK_ERR), .OVF_CNT(OVF_CNT)
    );

    always #5 CLKR = ~CLKR;

    // Model: state, remaining frames, buffered frame as a queue of channels still to send.
    int          m_st, m_rem, m_ovf;
    logic [7:0]  m_mask;
    bit          m_err, m_clast, h1, h2, h3;
    int          chq[$];
    logic [DW-1:0] m_frame [CHN];

    int checks = 0, errors = 0;
    int n_beats, n_flast, n_clast, clast_at, n_done;
    int obs_ch[$];

    task automatic model_reset();
        m_st = M_IDLE; m_rem = 0; m_ovf = 0; m_mask = '0;
        m_err = 0; m_clast = 0; h1 = 0; h2 = 0; h3 = 0;
        chq.delete();
    endtask

    task automatic clr_stats();
        n_beats = 0; n_flast = 0; n_clast = 0; clast_at = 0; n_done = 0;
        obs_ch.delete();
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic tick();
        bit ev, fl, cl, dn, was_empty, hs, trig, loss;
        int ch;
        #1;
        if (RST) model_reset();
        was_empty = (chq.size() == 0);
        ev   = !was_empty && !ABORT;
        fl   = ev && (chq.size() == 1);
        loss = (m_st == M_CAP) && !FRAME_OK && !ABORT;
        cl   = fl && (m_clast || loss);
        dn   = (m_st == M_DRN) && was_empty && !ABORT;
        checks++; if (OUT_VALID !== ev) begin errors++; $display("FAIL out_valid got %0b exp %0b t=%0t", OUT_VALID, ev, $time); end
        if (ev) begin
            ch = chq[0];
            checks++; if (OUT_CH !== 3'(ch)) begin errors++; $display("FAIL out_ch got %0d exp %0d t=%0t", OUT_CH, ch, $time); end
            checks++; if (OUT_DATA !== m_frame[ch]) begin errors++; $display("FAIL out_data got %0h exp %0h t=%0t", OUT_DATA, m_frame[ch], $time); end
            checks++; if (OUT_FLAST !== fl) begin errors++; $display("FAIL out_flast got %0b exp %0b t=%0t", OUT_FLAST, fl, $time); end
            checks++; if (OUT_CLAST !== cl) begin errors++; $display("FAIL out_clast got %0b exp %0b t=%0t", OUT_CLAST, cl, $time); end
        end
        checks++; if (BUSY !== (m_st != M_IDLE)) begin errors++; $display("FAIL busy got %0b exp %0b t=%0t", BUSY, m_st != M_IDLE, $time); end
        checks++; if (DONE !== dn) begin errors++; $display("FAIL done got %0b exp %0b t=%0t", DONE, dn, $time); end
        checks++; if (LINK_ERR !== m_err) begin errors++; $display("FAIL link_err got %0b exp %0b t=%0t", LINK_ERR, m_err, $time); end
        checks++; if (OVF_CNT !== 8'(m_ovf)) begin errors++; $display("FAIL ovf_cnt got %0d exp %0d t=%0t", OVF_CNT, m_ovf, $time); end
        if (OUT_VALID && OUT_READY) begin
            n_beats++;
            obs_ch.push_back(int'(OUT_CH));
            if (OUT_FLAST) n_flast++;
            if (OUT_CLAST) begin n_clast++; clast_at = n_beats; end
        end
        if (DONE) n_done++;
        hs   = ev && OUT_READY;
        trig = SW_TRIG || (h2 && !h3);
        @(posedge CLKR);
        if (RST) model_reset();
        else begin
            h3 = h2; h2 = h1; h1 = EXT_TRIG;
            if (hs) chq.delete(0);
            if (ABORT) begin
                m_st = M_IDLE; chq.delete();
            end else begin
                case (m_st)
                    M_IDLE: if (ARM && NSAMPLES != 0) begin
                        m_rem = int'(NSAMPLES); m_mask = CH_MASK; m_err = 0; m_ovf = 0; m_st = M_ARMD;
                    end
                    M_ARMD: if (trig && FRAME_OK) m_st = M_CAP;
                    M_CAP: begin
                        if (!FRAME_OK) begin
                            m_err = 1; m_clast = 1; m_st = M_DRN;
                        end else if (ENB) begin
                            m_rem--;
                            if (m_mask != 0) begin
                                if (chq.size() == 0) begin
                                    for (int i = 0; i < CHN; i++) begin
                                        m_frame[i] = DATA[i*DW +: DW];
                                        if (m_mask[i]) chq.push_back(i);
                                    end
                                    m_clast = (m_rem == 0);
                                end else if (m_ovf < 255) m_ovf++;
                            end
                            if (m_rem == 0) m_st = M_DRN;
                        end
                    end
                    M_DRN: if (dn) m_st = M_IDLE;
                    default: m_st = M_IDLE;
                endcase
            end
        end
        @(negedge CLKR);
    endtask

    task automatic do_arm(input int ns, input logic [7:0] m);
        NSAMPLES = CW'(ns); CH_MASK = m; ARM = 1; tick(); ARM = 0;
    endtask

    task automatic sw_trig();
        SW_TRIG = 1; tick(); SW_TRIG = 0;
    endtask

    // rmode 0: ready high; 1: random; 2: low inside [lo,hi). FRAME_OK drops from cycle fok_drop.
    task automatic drive(input int period, input int rmode, input int lo, input int hi,
                         input int fok_drop, input int budget);
        int c = 0;
        while (m_st != M_IDLE && c < budget) begin
            ENB  = (c % period) == (period - 1);
            DATA = {$urandom, $urandom, $urandom};
            OUT_READY = (rmode == 1) ? 1'($urandom_range(0, 1)) : ((rmode == 2) ? !(c >= lo && c < hi) : 1'b1);
            if (fok_drop >= 0 && c >= fok_drop) FRAME_OK = 0;
            tick();
            c++;
        end
        ENB = 0; OUT_READY = 1; FRAME_OK = 1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL drive_timeout busy got %0b exp 0", BUSY); end
    endtask

    task automatic test_reset();
        RST = 1; tick(); tick();
        checks++; if (OUT_CH !== 3'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", OUT_CH); end
        checks++; if (OUT_DATA !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", OUT_DATA); end
        checks++; if (OUT_FLAST !== 1'b0 || OUT_CLAST !== 1'b0) begin errors++; $display("FAIL reset_last got %0b%0b exp 00", OUT_FLAST, OUT_CLAST); end
        RST = 0; tick();
    endtask

    task automatic test_mask_framing();
        clr_stats(); do_arm(3, 8'hFF); sw_trig(); drive(10, 0, 0, 0, -1, 200);
        checks++; if (n_beats != 24) begin errors++; $display("FAIL frm_beats got %0d exp 24", n_beats); end
        checks++; if (n_flast != 3) begin errors++; $display("FAIL frm_flast got %0d exp 3", n_flast); end
        checks++; if (n_clast != 1 || clast_at != 24) begin errors++; $display("FAIL frm_clast got %0d@%0d exp 1@24", n_clast, clast_at); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL frm_done got %0d exp 1", n_done); end
        for (int i = 0; i < obs_ch.size(); i++) begin
            checks++; if (obs_ch[i] != i % 8) begin errors++; $display("FAIL frm_order got %0d exp %0d", obs_ch[i], i % 8); end
        end
    endtask

    task automatic test_sparse();
        clr_stats(); do_arm(4, 8'h05); sw_trig(); drive(5, 0, 0, 0, -1, 200);
        checks++; if (n_beats != 8) begin errors++; $display("FAIL sparse_beats got %0d exp 8", n_beats); end
        checks++; if (OVF_CNT !== 8'd0) begin errors++; $display("FAIL sparse_ovf got %0d exp 0", OVF_CNT); end
        for (int i = 0; i < obs_ch.size(); i++) begin
            checks++; if (obs_ch[i] != 2 * (i % 2)) begin errors++; $display("FAIL sparse_order got %0d exp %0d", obs_ch[i], 2 * (i % 2)); end
        end
    endtask

    task automatic test_backpressure();
        clr_stats(); do_arm(5, 8'hFF); sw_trig(); drive(6, 2, 0, 20, -1, 300);
        checks++; if (OVF_CNT !== 8'd3) begin errors++; $display("FAIL bp_ovf got %0d exp 3", OVF_CNT); end
        checks++; if (n_beats != 16) begin errors++; $display("FAIL bp_beats got %0d exp 16", n_beats); end
        checks++; if (n_done != 1 || n_clast != 1) begin errors++; $display("FAIL bp_done got %0d/%0d exp 1/1", n_done, n_clast); end
    endtask

    task automatic test_back_to_back();
        clr_stats(); do_arm(4, 8'hFF); sw_trig(); drive(8, 0, 0, 0, -1, 200);
        checks++; if (OVF_CNT !== 8'd0) begin errors++; $display("FAIL b2b_ovf got %0d exp 0", OVF_CNT); end
        checks++; if (n_beats != 32) begin errors++; $display("FAIL b2b_beats got %0d exp 32", n_beats); end
    endtask

    task automatic test_mask_zero();
        clr_stats(); do_arm(2, 8'h00); sw_trig(); drive(4, 0, 0, 0, -1, 100);
        checks++; if (n_beats != 0 || n_done != 1) begin errors++; $display("FAIL mask0 got beats %0d done %0d exp 0/1", n_beats, n_done); end
    endtask

    task automatic test_link_loss();
        clr_stats(); do_arm(10, 8'hFF); sw_trig(); drive(10, 0, 0, 0, 21, 300);
        checks++; if (LINK_ERR !== 1'b1) begin errors++; $display("FAIL link_err got %0b exp 1", LINK_ERR); end
        checks++; if (n_beats != 16 || clast_at != 16) begin errors++; $display("FAIL link_clast got %0d@%0d exp 16@16", n_beats, clast_at); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL link_done got %0d exp 1", n_done); end
        do_arm(2, 8'hFF); tick();
        checks++; if (LINK_ERR !== 1'b0) begin errors++; $display("FAIL link_clear got %0b exp 0", LINK_ERR); end
        ABORT = 1; tick(); ABORT = 0; tick();
    endtask

    task automatic test_abort_gating();
        clr_stats(); do_arm(6, 8'hFF); sw_trig();
        for (int c = 0; c < 5; c++) begin
            ENB = (c == 2); DATA = {$urandom, $urandom, $urandom}; OUT_READY = (c < 3); tick();
        end
        ENB = 1; ABORT = 1; tick(); ENB = 0; ABORT = 0; OUT_READY = 1; tick();
        checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL abort got v%0b b%0b exp 0/0", OUT_VALID, BUSY); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", n_done); end
        // Edge while link is down must not trigger; ARM while armed must not reload the count.
        do_arm(3, 8'hFF); FRAME_OK = 0; EXT_TRIG = 1;
        for (int c = 0; c < 5; c++) tick();
        FRAME_OK = 1; do_arm(1, 8'h01);
        for (int c = 0; c < 4; c++) begin ENB = (c == 1); tick(); end
        ENB = 0;
        checks++; if (BUSY !== 1'b1 || n_beats != 0) begin errors++; $display("FAIL trig_gate got b%0b beats %0d exp 1/0", BUSY, n_beats); end
        EXT_TRIG = 0; tick(); tick(); tick(); EXT_TRIG = 1;
        for (int c = 0; c < 4; c++) tick();
        EXT_TRIG = 0; drive(10, 0, 0, 0, -1, 200);
        checks++; if (n_beats != 24) begin errors++; $display("FAIL ext_trig got %0d exp 24", n_beats); end
        do_arm(0, 8'hFF); sw_trig(); tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL arm_zero got %0b exp 0", BUSY); end
    endtask

    task automatic test_reset_mid();
        do_arm(4, 8'hFF); sw_trig();
        for (int c = 0; c < 6; c++) begin ENB = (c == 1); DATA = {$urandom, $urandom, $urandom}; OUT_READY = 0; tick(); end
        ENB = 0; RST = 1; tick();
        checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid got v%0b b%0b exp 0/0", OUT_VALID, BUSY); end
        RST = 0; OUT_READY = 1; tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            do_arm($urandom_range(1, 6), 8'($urandom)); sw_trig();
            drive($urandom_range(3, 12), 1, 0, 0, -1, 400);
        end
    endtask

    initial begin
        model_reset(); clr_stats();
        test_reset();
        test_mask_framing();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_mask_zero();
        test_link_loss();
        test_abort_gating();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
